// File: rtl/mem_dep_counter_predictor_pkg.sv
// Shared scheduler types and constants for the memory-dependence predictor.
// It also holds the PC-to-table index function, generalised to any power-of-two table size.
package SchedulerTypes;

   localparam int CONF_MDT_ENTRY_NUM  = 128;
   localparam int RENAME_WIDTH        = 2;
   localparam int INSN_ADDR_BIT_WIDTH = 2;
   localparam int PC_WIDTH            = 32;

   typedef logic [PC_WIDTH-1:0] PC_Path;

   localparam int MDT_CNT_WIDTH    = 2;
   localparam int MDT_CLEAR_WIDTH  = 2;
   localparam int MDT_DECAY_PERIOD = 65536;

   typedef logic [MDT_CNT_WIDTH-1:0] MDT_CounterPath;

   typedef enum logic {
      MDT_ST_CLEAR,
      MDT_ST_RUN
   } mdt_state_e;

   // Drops the instruction-alignment bits, then keeps log2(entry_num) bits.
   function automatic PC_Path ToMDT_Index(input PC_Path pc, input int unsigned entry_num);
      return (pc >> INSN_ADDR_BIT_WIDTH) & PC_WIDTH'(entry_num - 1);
   endfunction

endpackage

// File: rtl/mem_dep_counter_predictor_clear_ctrl.sv
// Clear-walk FSM and decay timer for the dependence table.
// The walk zeroes CLEAR_WIDTH entries per cycle, then hands the table back to RUN.
module mem_dep_pred_clear_ctrl
   import SchedulerTypes::*;
#(
   parameter int ENTRY_NUM    = CONF_MDT_ENTRY_NUM,
   parameter int CLEAR_WIDTH  = MDT_CLEAR_WIDTH,
   parameter int DECAY_PERIOD = MDT_DECAY_PERIOD,
   localparam int IDX_W       = $clog2(ENTRY_NUM)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clearReq,
   output logic             busy,
   output logic [IDX_W-1:0] clearPtr,
   output logic             clearEnable
);

   localparam int DECAY_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
   localparam logic [DECAY_W-1:0] DECAY_LAST =
      (DECAY_PERIOD == 0) ? '0 : DECAY_W'(DECAY_PERIOD - 1);
   localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(ENTRY_NUM - CLEAR_WIDTH);
   localparam logic [IDX_W-1:0] PTR_STEP = IDX_W'(CLEAR_WIDTH);

   mdt_state_e         state_q, state_d;
   logic [IDX_W-1:0]   clear_ptr_q, clear_ptr_d;
   logic [DECAY_W-1:0] decay_q, decay_d;
   logic               clear_start;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      clear_ptr_d = clear_ptr_q;
      decay_d     = '0;
      clear_start = 1'b0;
      unique case (state_q)
         MDT_ST_CLEAR: begin
            if (clearReq) begin
               clear_ptr_d = '0;
            end else if (clear_ptr_q == LAST_PTR) begin
               state_d     = MDT_ST_RUN;
               clear_ptr_d = '0;
            end else begin
               clear_ptr_d = clear_ptr_q + PTR_STEP;
            end
         end
         MDT_ST_RUN: begin
            clear_start = clearReq || ((DECAY_PERIOD != 0) && (decay_q == DECAY_LAST));
            if (clear_start) begin
               state_d     = MDT_ST_CLEAR;
               clear_ptr_d = '0;
            end else if (DECAY_PERIOD != 0) begin
               decay_d = decay_q + 1'b1;
            end
         end
         default: state_d = MDT_ST_CLEAR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= MDT_ST_CLEAR;
         clear_ptr_q <= '0;
         decay_q     <= '0;
      end else begin
         state_q     <= state_d;
         clear_ptr_q <= clear_ptr_d;
         decay_q     <= decay_d;
      end
   end

   assign busy        = (state_q == MDT_ST_CLEAR);
   assign clearPtr    = clear_ptr_q;
   // Also raised on the cycle a walk starts, so that cycle's training is dropped.
   assign clearEnable = busy || clear_start;

endmodule

// File: rtl/mem_dep_counter_predictor.sv
// Memory-dependence predictor: a table of saturating counters indexed by load PC.
// A set MSB tells the scheduler to hold the load behind older stores.
module mem_dep_counter_predictor
   import SchedulerTypes::*;
#(
   parameter int ENTRY_NUM    = CONF_MDT_ENTRY_NUM,
   parameter int CNT_WIDTH    = MDT_CNT_WIDTH,
   parameter int LOOKUP_WIDTH = RENAME_WIDTH,
   parameter int TRAIN_WIDTH  = 2,
   parameter int CLEAR_WIDTH  = MDT_CLEAR_WIDTH,
   parameter int DECAY_PERIOD = MDT_DECAY_PERIOD
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LOOKUP_WIDTH-1:0] lookupValid,
   input  PC_Path                  lookupPC [LOOKUP_WIDTH],
   output logic [LOOKUP_WIDTH-1:0] predictDepend,
   input  logic [TRAIN_WIDTH-1:0]  trainValid,
   input  PC_Path                  trainPC [TRAIN_WIDTH],
   input  logic [TRAIN_WIDTH-1:0]  trainViolation,
   input  logic                    clearReq,
   output logic                    busy
);

   localparam int IDX_W = $clog2(ENTRY_NUM);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [IDX_W-1:0] GROUP_MASK = ~IDX_W'(CLEAR_WIDTH - 1);

   logic [IDX_W-1:0]        clear_ptr;
   logic                    clear_en;
   logic [CNT_WIDTH-1:0]    cnt_q [ENTRY_NUM];
   logic [CNT_WIDTH-1:0]    cnt_d [ENTRY_NUM];
   logic [ENTRY_NUM-1:0]    viol_hit, dec_hit;
   logic [LOOKUP_WIDTH-1:0] predict_q, predict_d;

   mem_dep_pred_clear_ctrl #(
      .ENTRY_NUM   (ENTRY_NUM),
      .CLEAR_WIDTH (CLEAR_WIDTH),
      .DECAY_PERIOD(DECAY_PERIOD)
   ) u_clear_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .clearReq   (clearReq),
      .busy       (busy),
      .clearPtr   (clear_ptr),
      .clearEnable(clear_en)
   );

   // Merge the train ports per entry: any violation wins, otherwise one decrement.
   always_comb begin
      viol_hit = '0;
      dec_hit  = '0;
      for (int p = 0; p < TRAIN_WIDTH; p++) begin
         if (trainValid[p]) begin
            if (trainViolation[p]) viol_hit[IDX_W'(ToMDT_Index(trainPC[p], ENTRY_NUM))] = 1'b1;
            else                   dec_hit[IDX_W'(ToMDT_Index(trainPC[p], ENTRY_NUM))]  = 1'b1;
         end
      end
   end

   always_comb begin
      for (int e = 0; e < ENTRY_NUM; e++) begin
         cnt_d[e] = cnt_q[e];
         if (clear_en) begin
            if ((IDX_W'(e) & GROUP_MASK) == clear_ptr) cnt_d[e] = '0;
         end else if (viol_hit[e]) begin
            cnt_d[e] = CNT_MAX;
         end else if (dec_hit[e] && (cnt_q[e] != '0)) begin
            cnt_d[e] = cnt_q[e] - 1'b1;
         end
      end
   end

   // Reads the pre-training counter: no same-cycle bypass.
   always_comb begin
      predict_d = '0;
      for (int i = 0; i < LOOKUP_WIDTH; i++) begin
         predict_d[i] = lookupValid[i] && !busy &&
                        cnt_q[IDX_W'(ToMDT_Index(lookupPC[i], ENTRY_NUM))][CNT_WIDTH-1];
      end
   end

   // NOTE: the counter array has no reset; the clear walk that follows every reset zeroes it.
   always_ff @(posedge clk) begin
      for (int e = 0; e < ENTRY_NUM; e++) cnt_q[e] <= cnt_d[e];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) predict_q <= '0;
      else        predict_q <= predict_d;
   end

   assign predictDepend = predict_q;

endmodule

// File: tb/tb_mem_dep_counter_predictor.sv
// Directed bench for mem_dep_counter_predictor with a 16-entry, 2-bit table.
// Entry index is pc[5:2]: 0x100->0, 0x104/0x144->1, 0x108->2, 0x10C->3.
module tb_mem_dep_counter_predictor;
   import SchedulerTypes::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] lookup_valid;
   PC_Path     lookup_pc [2];
   logic [1:0] predict_depend;
   logic [1:0] train_valid;
   PC_Path     train_pc [2];
   logic [1:0] train_violation;
   logic       clear_req;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_dep_counter_predictor #(
      .ENTRY_NUM   (16),
      .CNT_WIDTH   (2),
      .LOOKUP_WIDTH(2),
      .TRAIN_WIDTH (2),
      .CLEAR_WIDTH (4),
      .DECAY_PERIOD(64)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .lookupValid   (lookup_valid),
      .lookupPC      (lookup_pc),
      .predictDepend (predict_depend),
      .trainValid    (train_valid),
      .trainPC       (train_pc),
      .trainViolation(train_violation),
      .clearReq      (clear_req),
      .busy          (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      lookup_valid    = 2'b00;
      lookup_pc[0]    = '0;
      lookup_pc[1]    = '0;
      train_valid     = 2'b00;
      train_pc[0]     = '0;
      train_pc[1]     = '0;
      train_violation = 2'b00;
      clear_req       = 1'b0;
   endtask

   // Lookup pc0 on port 0 (and pc1 on port 1 if v1) for one cycle, return result.
   task automatic lookup(input PC_Path pc0, input logic v1, input PC_Path pc1, output logic [1:0] res);
      lookup_valid = {v1, 1'b1};
      lookup_pc[0] = pc0;
      lookup_pc[1] = pc1;
      tick();
      lookup_valid = 2'b00;
      res = predict_depend;
   endtask

   task automatic train1(input PC_Path pc, input logic viol);
      train_valid     = 2'b01;
      train_pc[0]     = pc;
      train_violation = {1'b0, viol};
      tick();
      train_valid     = 2'b00;
      train_violation = 2'b00;
   endtask

   task automatic wait_walk_done(input string name);
      int n = 0;
      while (busy && n < 20) begin
         tick();
         n++;
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_walk_timeout: busy=%b after %0d cycles, want 0", name, busy, n);
      end
   endtask

   task automatic restart();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wait_walk_done("restart");
   endtask

   task automatic test_reset();
      logic [1:0] r;
      idle_inputs();
      rst_n = 1'b0;
      lookup_valid = 2'b11;
      tick();
      tick();
      lookup_valid = 2'b00;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++; $display("FAIL reset_busy: got %b want 1", busy);
      end
      vectors++;
      if (predict_depend !== 2'b00) begin
         miscompares++; $display("FAIL reset_predict: got %b want 00", predict_depend);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (busy !== 1'b1) begin
            miscompares++; $display("FAIL reset_walk_busy[%0d]: got %b want 1", k, busy);
         end
         tick();
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++; $display("FAIL reset_walk_end: got %b want 0", busy);
      end
      lookup(32'h100, 1'b0, '0, r);
      vectors++;
      if (r !== 2'b00) begin
         miscompares++; $display("FAIL reset_lookup_0x100: got %b want 00", r);
      end
   endtask

   task automatic test_violation();
      logic [1:0] r;
      restart();
      train1(32'h104, 1'b1);
      lookup(32'h104, 1'b1, 32'h144, r);
      vectors++;
      if (r !== 2'b11) begin
         miscompares++; $display("FAIL viol_alias_lookup: got %b want 11", r);
      end
      lookup(32'h108, 1'b0, 32'h104, r);
      vectors++;
      if (r !== 2'b00) begin
         miscompares++; $display("FAIL viol_other_entry_and_invalid: got %b want 00", r);
      end
   endtask

   // Continues from test_violation: entry 1 holds 3.
   task automatic test_decrement();
      logic [1:0] r;
      train1(32'h104, 1'b0);
      lookup(32'h104, 1'b0, '0, r);
      vectors++;
      if (r !== 2'b01) begin
         miscompares++; $display("FAIL dec_first (cnt 2): got %b want 01", r);
      end
      train1(32'h104, 1'b0);
      lookup(32'h104, 1'b0, '0, r);
      vectors++;
      if (r !== 2'b00) begin
         miscompares++; $display("FAIL dec_second (cnt 1): got %b want 00", r);
      end
      train1(32'h104, 1'b0);
      train1(32'h104, 1'b0);
      lookup(32'h104, 1'b0, '0, r);
      vectors++;
      if (r !== 2'b00) begin
         miscompares++; $display("FAIL dec_saturate_zero: got %b want 00", r);
      end
   endtask

   task automatic test_same_cycle();
      logic [1:0] r;
      restart();
      train_valid     = 2'b11;
      train_pc[0]     = 32'h108;
      train_pc[1]     = 32'h108;
      train_violation = 2'b10;
      lookup(32'h108, 1'b0, '0, r);
      train_valid     = 2'b00;
      train_violation = 2'b00;
      vectors++;
      if (r !== 2'b00) begin
         miscompares++; $display("FAIL same_cycle_no_bypass: got %b want 00", r);
      end
      lookup(32'h108, 1'b0, '0, r);
      vectors++;
      if (r !== 2'b01) begin
         miscompares++; $display("FAIL same_cycle_viol_wins: got %b want 01", r);
      end
      train_valid     = 2'b11;
      train_violation = 2'b00;
      tick();
      train_valid     = 2'b00;
      lookup(32'h108, 1'b0, '0, r);
      vectors++;
      if (r !== 2'b01) begin
         miscompares++; $display("FAIL same_cycle_single_dec (cnt 2): got %b want 01", r);
      end
   endtask

   task automatic test_clear_restart();
      logic [1:0] r;
      restart();
      clear_req = 1'b1;
      train1(32'h104, 1'b1);
      clear_req = 1'b0;
      tick();
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (busy !== 1'b1) begin
            miscompares++; $display("FAIL clear_restart_busy[%0d]: got %b want 1", k, busy);
         end
         train1(32'h100, 1'b1);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++; $display("FAIL clear_restart_end: got %b want 0", busy);
      end
      lookup(32'h100, 1'b1, 32'h104, r);
      vectors++;
      if (r !== 2'b00) begin
         miscompares++; $display("FAIL clear_train_ignored: got %b want 00", r);
      end
   endtask

   task automatic test_decay();
      logic [1:0] r;
      int run_cycles;
      int busy_cycles;
      restart();
      train1(32'h10C, 1'b1);
      lookup(32'h10C, 1'b0, '0, r);
      vectors++;
      if (r !== 2'b01) begin
         miscompares++; $display("FAIL decay_trained: got %b want 01", r);
      end
      run_cycles = 2;
      while (!busy && run_cycles < 200) begin
         tick();
         run_cycles++;
      end
      vectors++;
      if (run_cycles !== 64) begin
         miscompares++; $display("FAIL decay_period: got %0d run cycles want 64", run_cycles);
      end
      busy_cycles = 0;
      while (busy && busy_cycles < 20) begin
         tick();
         busy_cycles++;
      end
      vectors++;
      if (busy_cycles !== 4) begin
         miscompares++; $display("FAIL decay_walk_len: got %0d want 4", busy_cycles);
      end
      lookup(32'h10C, 1'b0, '0, r);
      vectors++;
      if (r !== 2'b00) begin
         miscompares++; $display("FAIL decay_cleared: got %b want 00", r);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] r;
      restart();
      train1(32'h104, 1'b1);
      rst_n = 1'b0;
      lookup(32'h104, 1'b0, '0, r);
      vectors++;
      if (r !== 2'b00 || busy !== 1'b1) begin
         miscompares++; $display("FAIL reset_mid_run: predict %b busy %b want 00/1", r, busy);
      end
      rst_n = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (busy !== 1'b1) begin
            miscompares++; $display("FAIL reset_mid_walk_busy[%0d]: got %b want 1", k, busy);
         end
         tick();
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++; $display("FAIL reset_mid_walk_end: got %b want 0", busy);
      end
      lookup(32'h104, 1'b0, '0, r);
      vectors++;
      if (r !== 2'b00) begin
         miscompares++; $display("FAIL reset_mid_cleared: got %b want 00", r);
      end
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      test_reset();
      test_violation();
      test_decrement();
      test_same_cycle();
      test_clear_restart();
      test_decay();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
